fp_addsub_top: RTL and testbench
================================

Name: fp_addsub_top

Overview:
Multi-cycle IEEE-754 single-precision floating-point adder/subtractor with a start/busy/ready handshake.
- Computes data_a + data_b (op=0) or data_a - data_b (op=1).
- Top level of the arithmetic unit; driven by a host that pulses start and waits for busy to fall.

Parameters:
- None. Format is fixed: 1 sign bit, 8-bit exponent (bias 127), 23-bit fraction.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  1  0 = add, 1 = subtract (a - b).
- data_a  in  32  operand A, IEEE-754 single.
- data_b  in  32  operand B, IEEE-754 single.
- busy  out  1  high while an operation is in progress.
- ready  out  1  one-cycle pulse when data_o is valid.
- data_o  out  32  result; held stable until the next accepted start.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While reset=0: state=IDLE, busy=0, ready=0, data_o=0. Reset mid-operation aborts it; no ready pulse follows.
- Start acceptance: in IDLE with start=1 at a clock edge:
  - latch data_a, data_b and op;
  - for op=1, invert B's sign;
  - set busy=1 from the next cycle.
  - start is ignored while busy=1 or ready=1.
- States: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> PACK -> DONE -> IDLE.
- UNPACK:
  - Exponent 0 means zero; denormals are flushed to zero.
  - Otherwise prepend the hidden 1 to form a 24-bit significand and append guard, round and sticky bits (27 bits).
  - Detect special inputs; any special input goes directly to PACK.
- ALIGN:
  - Swap operands so the larger magnitude is first.
  - Right-shift the smaller significand one bit per cycle until exponents match. Shifted-out bits OR into sticky.
  - If the exponent difference exceeds 26, the smaller operand collapses to sticky only, in one cycle.
- ADD:
  - Equal signs: add magnitudes. Different signs: subtract smaller from larger.
  - Result sign is the larger operand's sign.
  - An exact zero result is +0 (either sign of zero inputs gives +0, except -0 + -0 = -0).
- NORM:
  - On carry-out, right-shift 1 and increment the exponent (once).
  - Otherwise left-shift one bit per cycle until bit 23 is set, decrementing the exponent each shift.
  - Exponent reaching 0 or below gives a signed zero.
  - Exponent reaching 255 or above gives a signed infinity.
- Rounding: round toward zero. Guard, round and sticky bits are discarded; no increment.
- Specials:
  - Any NaN input, or inf - inf, gives 0x7FC00000.
  - inf plus a finite value gives that inf.
  - inf + inf of the same sign gives that inf.
- PACK: assemble {sign, exp[7:0], frac[22:0]} into data_o.
- DONE: ready=1 for exactly one cycle; busy falls in the same cycle; return to IDLE.
- Latency: variable, bounded by 64 cycles. The host must wait for busy=0 / ready.
- data_o is unchanged from PACK until the next result.

Decomposition:
- Shared package fp_pkg holds:
  - state enum (IDLE, UNPACK, ALIGN, ADD, NORM, PACK, DONE);
  - constants EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, FRAC_W=23, EXT_W=27.
- One natural sub-module: fp_unpack. It is combinational and produces sign, exponent, extended significand and is_zero/is_inf/is_nan flags. Instantiate it once per operand.

Test Plan:
- 400000.0 - (-399998.0): op=1, a=0x48C35000, b=0xC8C34FC0 -> data_o=0x49434FE0, ready pulses once, busy then low.
- 1.0 + 1.0 (0x3F800000 + 0x3F800000) -> 0x40000000. 1.0 - 2.0 (op=1, b=0x40000000) -> 0xBF800000.
- Cancellation and zero:
  - 0x48C35000 + 0xC8C35000 -> 0x00000000.
  - 0x80000000 + 0x80000000 -> 0x80000000.
- Rounding and sticky:
  - 1.0 - 2^-30 (op=1, a=0x3F800000, b=0x30800000) -> 0x3F7FFFFF.
  - 1.0 + 2^-30 -> 0x3F800000.
- Overflow and specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000.
  - NaN 0x7FC00001 + 1.0 -> 0x7FC00000.
- Handshake and reset:
  - A second start while busy is ignored; the result still matches the first operands.
  - Driving reset=0 mid-ALIGN gives busy=0, ready=0, data_o=0 immediately; no ready pulse follows.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared types and constants for the single-precision
//               floating-point add/subtract unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam int          FRAC_W   = 23;
    // Hidden bit + fraction + guard/round/sticky
    localparam int          EXT_W    = 27;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
        PACK   = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fp_unpack
// Description : Combinational field extraction for one IEEE-754 single
//               operand. Zero exponents (zeros and denormals) are flushed to
//               a zero significand; normals get the hidden one prepended and
//               three low bits reserved for guard, round and sticky.
// Ports       : i_word     - operand word
//               o_sign     - sign bit
//               o_exp      - biased exponent (0 for zero/denormal)
//               o_sig      - 27-bit extended significand
//               o_is_zero  - zero or flushed denormal
//               o_is_inf   - infinity
//               o_is_nan   - any NaN
// Revision    : 1.0 - initial release
// ============================================================================
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]      i_word,
    output logic             o_sign,
    output logic [7:0]       o_exp,
    output logic [EXT_W-1:0] o_sig,
    output logic             o_is_zero,
    output logic             o_is_inf,
    output logic             o_is_nan
);

    logic [7:0]        w_exp_field;
    logic [FRAC_W-1:0] w_frac;
    logic              w_exp_all_ones;

    assign w_exp_field    = i_word[30:23];
    assign w_frac         = i_word[FRAC_W-1:0];
    assign w_exp_all_ones = (w_exp_field == 8'(EXP_MAX));

    assign o_sign    = i_word[31];
    assign o_is_zero = (w_exp_field == 8'd0);
    assign o_is_inf  = w_exp_all_ones && (w_frac == '0);
    assign o_is_nan  = w_exp_all_ones && (w_frac != '0);
    assign o_exp     = w_exp_field;
    assign o_sig     = o_is_zero ? '0 : {1'b1, w_frac, 3'b000};

endmodule
`default_nettype wire

// File: rtl/fp_addsub_top.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_top
// Description : Multi-cycle IEEE-754 single-precision adder/subtractor with a
//               start/busy/ready handshake. Rounds toward zero, flushes
//               denormals, returns a canonical quiet NaN for invalid cases.
// Ports       : clock  - system clock, rising edge
//               reset  - asynchronous active-low reset
//               start  - one-cycle request, sampled only in IDLE
//               op     - 0 = add, 1 = subtract (a - b)
//               data_a - operand A
//               data_b - operand B
//               busy   - high while an operation is in progress
//               ready  - one-cycle pulse when data_o is valid
//               data_o - result, held until the next result is packed
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_top
    import fp_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic        busy,
    output logic        ready,
    output logic [31:0] data_o
);

    state_t             r_state;
    logic [31:0]        r_word_a;
    logic [31:0]        r_word_b;      // B with sign already flipped for subtract
    logic               r_ordered;     // operands swapped into magnitude order
    logic               r_sign_x;      // x = larger magnitude once ordered
    logic [7:0]         r_exp_x;       // also the working exponent in NORM
    logic [EXT_W-1:0]   r_sig_x;
    logic               r_sign_y;
    logic [7:0]         r_exp_y;
    logic [EXT_W-1:0]   r_sig_y;
    logic               r_sign_r;
    logic [EXT_W:0]     r_sum;         // extra top bit catches the carry-out
    logic               r_special;     // result fully decided, bypass field packing
    logic [31:0]        r_special_word;

    logic               w_sign_a, w_sign_b;
    logic [7:0]         w_exp_a, w_exp_b;
    logic [EXT_W-1:0]   w_sig_a, w_sig_b;
    logic               w_zero_a, w_zero_b;
    logic               w_inf_a, w_inf_b;
    logic               w_nan_a, w_nan_b;

    logic               w_special;
    logic [31:0]        w_special_word;
    logic               w_y_larger;
    logic [7:0]         w_exp_diff;
    logic [EXT_W:0]     w_sum;

    fp_unpack u_unpack_a (
        .i_word    (r_word_a),
        .o_sign    (w_sign_a),
        .o_exp     (w_exp_a),
        .o_sig     (w_sig_a),
        .o_is_zero (w_zero_a),
        .o_is_inf  (w_inf_a),
        .o_is_nan  (w_nan_a)
    );

    fp_unpack u_unpack_b (
        .i_word    (r_word_b),
        .o_sign    (w_sign_b),
        .o_exp     (w_exp_b),
        .o_sig     (w_sig_b),
        .o_is_zero (w_zero_b),
        .o_is_inf  (w_inf_b),
        .o_is_nan  (w_nan_b)
    );

    // Zero inputs need no special path: a zero significand flows through
    // alignment and addition unchanged.
    logic w_unused_zero;
    assign w_unused_zero = w_zero_a ^ w_zero_b;

    // Special-operand resolution. B's sign is already the effective sign, so
    // inf - inf shows up here as infinities of opposite sign.
    always_comb begin
        w_special      = 1'b0;
        w_special_word = QNAN;
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sign_a != w_sign_b))) begin
            w_special      = 1'b1;
            w_special_word = QNAN;
        end else if (w_inf_a) begin
            w_special      = 1'b1;
            w_special_word = {w_sign_a, 8'(EXP_MAX), {FRAC_W{1'b0}}};
        end else if (w_inf_b) begin
            w_special      = 1'b1;
            w_special_word = {w_sign_b, 8'(EXP_MAX), {FRAC_W{1'b0}}};
        end
    end

    assign w_y_larger = {r_exp_y, r_sig_y} > {r_exp_x, r_sig_x};
    assign w_exp_diff = r_exp_x - r_exp_y;

    // Magnitudes are ordered and aligned, so the subtraction never borrows.
    always_comb begin
        w_sum = '0;
        if (r_sign_x == r_sign_y) begin
            w_sum = {1'b0, r_sig_x} + {1'b0, r_sig_y};
        end else begin
            w_sum = {1'b0, r_sig_x} - {1'b0, r_sig_y};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_word_a       <= '0;
            r_word_b       <= '0;
            r_ordered      <= 1'b0;
            r_sign_x       <= 1'b0;
            r_exp_x        <= '0;
            r_sig_x        <= '0;
            r_sign_y       <= 1'b0;
            r_exp_y        <= '0;
            r_sig_y        <= '0;
            r_sign_r       <= 1'b0;
            r_sum          <= '0;
            r_special      <= 1'b0;
            r_special_word <= '0;
            busy           <= 1'b0;
            ready          <= 1'b0;
            data_o         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_word_a  <= data_a;
                        r_word_b  <= {data_b[31] ^ op, data_b[30:0]};
                        r_special <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= UNPACK;
                    end
                end

                UNPACK: begin
                    r_sign_x       <= w_sign_a;
                    r_exp_x        <= w_exp_a;
                    r_sig_x        <= w_sig_a;
                    r_sign_y       <= w_sign_b;
                    r_exp_y        <= w_exp_b;
                    r_sig_y        <= w_sig_b;
                    r_ordered      <= 1'b0;
                    r_special      <= w_special;
                    r_special_word <= w_special_word;
                    r_state        <= w_special ? PACK : ALIGN;
                end

                ALIGN: begin
                    if (!r_ordered) begin
                        r_ordered <= 1'b1;
                        if (w_y_larger) begin
                            r_sign_x <= r_sign_y;
                            r_exp_x  <= r_exp_y;
                            r_sig_x  <= r_sig_y;
                            r_sign_y <= r_sign_x;
                            r_exp_y  <= r_exp_x;
                            r_sig_y  <= r_sig_x;
                        end
                    end else if (r_exp_x == r_exp_y) begin
                        r_state <= ADD;
                    end else if (w_exp_diff > 8'(EXT_W - 1)) begin
                        // Every significand bit would be shifted out anyway.
                        r_sig_y <= {{(EXT_W-1){1'b0}}, |r_sig_y};
                        r_exp_y <= r_exp_x;
                    end else begin
                        // Bit 0 is sticky: it keeps whatever falls off.
                        r_sig_y <= {1'b0, r_sig_y[EXT_W-1:2], r_sig_y[1] | r_sig_y[0]};
                        r_exp_y <= r_exp_y + 8'd1;
                    end
                end

                ADD: begin
                    r_sign_r <= r_sign_x;
                    r_sum    <= w_sum;
                    if (w_sum == '0) begin
                        // Only -0 + -0 keeps a negative sign.
                        r_special      <= 1'b1;
                        r_special_word <= {r_sign_x & r_sign_y, 31'd0};
                        r_state        <= PACK;
                    end else begin
                        r_state <= NORM;
                    end
                end

                NORM: begin
                    if (r_sum[EXT_W]) begin
                        if (r_exp_x >= 8'(EXP_MAX - 1)) begin
                            r_special      <= 1'b1;
                            r_special_word <= {r_sign_r, 8'(EXP_MAX), {FRAC_W{1'b0}}};
                        end else begin
                            r_sum   <= {1'b0, r_sum[EXT_W:2], r_sum[1] | r_sum[0]};
                            r_exp_x <= r_exp_x + 8'd1;
                        end
                        r_state <= PACK;
                    end else if (r_sum[EXT_W-1]) begin
                        r_state <= PACK;
                    end else if (r_exp_x <= 8'd1) begin
                        // Next shift would take the exponent to zero.
                        r_special      <= 1'b1;
                        r_special_word <= {r_sign_r, 31'd0};
                        r_state        <= PACK;
                    end else begin
                        r_sum   <= {r_sum[EXT_W-1:0], 1'b0};
                        r_exp_x <= r_exp_x - 8'd1;
                    end
                end

                PACK: begin
                    // Truncation: guard/round/sticky in r_sum[2:0] are dropped.
                    data_o  <= r_special ? r_special_word
                                         : {r_sign_r, r_exp_x, r_sum[EXT_W-2:3]};
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= DONE;
                end

                DONE: begin
                    ready   <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_addsub_top
// Description : Self-checking bench for fp_addsub_top. Expected results are
//               queued when an operation is issued and compared when ready
//               pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_top;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        busy;
    logic        ready;
    logic [31:0] data_o;

    fp_addsub_top dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .data_a (data_a),
        .data_b (data_b),
        .busy   (busy),
        .ready  (ready),
        .data_o (data_o)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp_v);
        end
    endtask

    // Waits (bounded) for ready, pops the scoreboard and checks the result,
    // the busy/ready relationship, the single-cycle pulse and data hold.
    task automatic wait_result(input string tag);
        logic [31:0] exp_v;
        bit          seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clock);
            if (ready) seen = 1'b1;
        end
        check_eq({tag, "_ready_seen"}, {31'd0, seen}, 32'd1);
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            if (seen) begin
                check_eq(tag, data_o, exp_v);
                check_eq({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
                @(negedge clock);
                check_eq({tag, "_one_pulse"}, {31'd0, ready}, 32'd0);
                @(negedge clock);
                check_eq({tag, "_hold"}, data_o, exp_v);
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input logic [31:0] exp_v);
        @(negedge clock);
        data_a = a;
        data_b = b;
        op     = o;
        start  = 1'b1;
        sb_q.push_back(exp_v);
        @(negedge clock);
        start  = 1'b0;
        // Scramble inputs so the result depends on the latched operands only.
        data_a = $urandom;
        data_b = $urandom;
        op     = ~o;
        check_eq({tag, "_busy_high"}, {31'd0, busy}, 32'd1);
        wait_result(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        int ready_cnt;
        reset  = 1'b0;
        start  = 1'b0;
        op     = 1'b0;
        data_a = '0;
        data_b = '0;
        #1;
        check_eq("rst_busy",  {31'd0, busy},  32'd0);
        check_eq("rst_ready", {31'd0, ready}, 32'd0);
        check_eq("rst_data",  data_o,         32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        run_op("sub_large",     32'h48C35000, 32'hC8C34FC0, 1'b1, 32'h49434FE0);
        run_op("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        run_op("one_minus_two", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000);
        run_op("two_plus_one",  32'h40000000, 32'h3F800000, 1'b0, 32'h40400000);
        run_op("cancel",        32'h48C35000, 32'hC8C35000, 1'b0, 32'h00000000);
        run_op("negz_negz",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
        run_op("posz_negz",     32'h00000000, 32'h80000000, 1'b0, 32'h00000000);
        run_op("zero_plus_one", 32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000);
        run_op("sticky_sub",    32'h3F800000, 32'h30800000, 1'b1, 32'h3F7FFFFF);
        run_op("sticky_add",    32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000);
        run_op("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
        run_op("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
        run_op("nan_in",        32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000);
        run_op("fin_plus_ninf", 32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000);
        run_op("fin_minus_ninf",32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000);
        run_op("inf_plus_inf",  32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000);
        run_op("denorm_flush",  32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000);
        run_op("minnorm_dbl",   32'h00800000, 32'h00800000, 1'b0, 32'h01000000);
        run_op("underflow",     32'h00800000, 32'h00800001, 1'b1, 32'h80000000);

        // A start held high while busy must not replace the operands.
        @(negedge clock);
        data_a = 32'h3F800000;
        data_b = 32'h3F800000;
        op     = 1'b0;
        start  = 1'b1;
        sb_q.push_back(32'h40000000);
        @(negedge clock);
        data_a = 32'h40400000;
        data_b = 32'h48C35000;
        op     = 1'b1;
        repeat (3) @(negedge clock);
        start  = 1'b0;
        wait_result("ignore_start");

        // Abort during alignment (1.0 + 2^-20 needs many shift cycles).
        @(negedge clock);
        data_a = 32'h3F800000;
        data_b = 32'h35800000;
        op     = 1'b0;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("abort_busy",  {31'd0, busy},  32'd0);
        check_eq("abort_ready", {31'd0, ready}, 32'd0);
        check_eq("abort_data",  data_o,         32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        ready_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (ready) ready_cnt++;
        end
        check_eq("abort_no_ready", 32'(ready_cnt), 32'd0);

        run_op("after_abort",   32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
